spmv_ctrl: RTL and testbench

- Sequencer for the CSR sparse matrix-vector multiply datapath (FP16 A x B into a 16-entry result register file).
- Walks a CSR row-pointer vector and issues non-zero indices to the value/column-index memory, then issues x-vector addresses from the returned column indices.
- Delivers row-aligned first/last/zero-row tags and the running element count to the MAC datapath.
- Handles empty rows, stalls, malformed pointers and completion.

---
 rtl/spmv_pkg.sv | 24 ++
 rtl/spmv_tag_pipe.sv | 23 ++
 rtl/spmv_ctrl.sv | 149 ++++++++++++++
 tb/tb_spmv_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared types and sizes for the CSR sparse matrix-vector multiply sequencer.
package spmv_pkg;

  localparam int N_ROWS = 16;
  localparam int IDX_W  = 8;
  localparam int ROW_W  = $clog2(N_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  // One issued token: an element of a row, or the marker of an empty row.
  typedef struct packed {
    logic             valid;
    logic             zero;
    logic             first;
    logic             last;
    logic [ROW_W-1:0] row;
  } tag_t;

endpackage

// File: rtl/spmv_tag_pipe.sv
// Two-stage tag delay line matching the fixed latency of the value/column and x memories.
module spmv_tag_pipe
  import spmv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t stage1,
  output tag_t stage2
);

  // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= tag_in;
      stage2 <= stage1;
    end
  end

endmodule

// File: rtl/spmv_ctrl.sv
// CSR row-pointer walker: issues nnz reads, x-vector reads and row-aligned MAC tags.
module spmv_ctrl
  import spmv_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_start,
  input  logic [(N_ROWS+1)*IDX_W-1:0] i_row_ptr,
  input  logic                        i_stall,
  input  logic [IDX_W-1:0]            i_col_idx,
  output logic                        o_rd_en,
  output logic [IDX_W-1:0]            o_rd_addr,
  output logic                        o_x_rd_en,
  output logic [IDX_W-1:0]            o_x_addr,
  output logic                        o_mac_valid,
  output logic                        o_mac_first,
  output logic                        o_mac_last,
  output logic                        o_mac_zero,
  output logic [ROW_W-1:0]            o_mac_row,
  output logic [IDX_W-1:0]            o_count,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] row_ptr [N_ROWS+1];
  logic [ROW_W-1:0] r, r_nxt;
  logic [ROW_W:0]   r_ext;
  logic [IDX_W-1:0] k, k_nxt;
  logic [IDX_W-1:0] lo, hi;
  logic [IDX_W-1:0] count;
  logic             busy, busy_nxt, done, done_nxt, err, err_nxt;
  logic             ptr_bad, advance, accept;
  tag_t             issue, stage1, stage2;

  assign accept = (state == IDLE) && i_start;
  assign r_ext  = {1'b0, r};
  assign lo     = row_ptr[r_ext];
  assign hi     = row_ptr[r_ext + 1'b1];

  always_comb begin
    ptr_bad = 1'b0;
    for (int j = 0; j < N_ROWS; j++)
      if (row_ptr[j+1] < row_ptr[j]) ptr_bad = 1'b1;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    k_nxt     = k;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    advance   = 1'b0;
    issue     = '0;
    case (state)
      IDLE: if (i_start) begin
        state_nxt = LOAD;
        busy_nxt  = 1'b1;
      end
      LOAD: begin
        r_nxt = '0;
        k_nxt = row_ptr[0];
        if (ptr_bad) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: if (!i_stall) begin
        issue.valid = 1'b1;
        issue.row   = r;
        if (lo == hi) begin
          issue.zero = 1'b1;
          advance    = 1'b1;
        end else begin
          issue.first = (k == lo);
          issue.last  = (k == hi - 1'b1);
          k_nxt       = k + 1'b1;
          advance     = issue.last;
        end
        if (advance) begin
          r_nxt = r + 1'b1;
          if (r == ROW_W'(N_ROWS - 1)) state_nxt = DRAIN;
        end
      end
      // Once stage 1 is empty the final tag sits in stage 2, so done lands one cycle after it.
      DRAIN: if (!stage1.valid) begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      r     <= '0;
      k     <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      k     <= k_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      if (accept)           count <= '0;
      else if (o_mac_valid) count <= count + 1'b1;
    end
  end

  // NOTE: the pointer copy is not reset; it is only read after a start has loaded it.
  always_ff @(posedge i_clk) begin
    if (accept)
      for (int j = 0; j <= N_ROWS; j++) row_ptr[j] <= i_row_ptr[j*IDX_W +: IDX_W];
  end

  spmv_tag_pipe u_tag_pipe (
    .clk    (i_clk),
    .rst_n  (i_rstn),
    .tag_in (issue),
    .stage1 (stage1),
    .stage2 (stage2)
  );

  assign o_rd_en     = issue.valid & ~issue.zero;
  assign o_rd_addr   = o_rd_en ? k : '0;
  assign o_x_rd_en   = stage1.valid & ~stage1.zero;
  assign o_x_addr    = o_x_rd_en ? i_col_idx : '0;
  assign o_mac_valid = stage2.valid & ~stage2.zero;
  assign o_mac_zero  = stage2.valid & stage2.zero;
  assign o_mac_first = o_mac_valid & stage2.first;
  assign o_mac_last  = o_mac_valid & stage2.last;
  assign o_mac_row   = stage2.row;
  assign o_count     = count;
  assign o_busy      = busy;
  assign o_done      = done;
  assign o_err       = err;

endmodule

// File: tb/tb_spmv_ctrl.sv
// Directed bench for spmv_ctrl: table of pointer vectors plus reset/restart sequences.
`timescale 1ns/1ps
module tb_spmv_ctrl;
  import spmv_pkg::*;

  localparam int PTR_W = (N_ROWS + 1) * IDX_W;

  logic               i_clk = 1'b0;
  logic               i_rstn, i_start, i_stall;
  logic [PTR_W-1:0]   i_row_ptr;
  logic [IDX_W-1:0]   i_col_idx;
  logic               o_rd_en, o_x_rd_en, o_mac_valid, o_mac_first, o_mac_last, o_mac_zero;
  logic [IDX_W-1:0]   o_rd_addr, o_x_addr, o_count;
  logic [ROW_W-1:0]   o_mac_row;
  logic               o_busy, o_done, o_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  spmv_ctrl dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_row_ptr   (i_row_ptr),
    .i_stall     (i_stall),
    .i_col_idx   (i_col_idx),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .o_x_rd_en   (o_x_rd_en),
    .o_x_addr    (o_x_addr),
    .o_mac_valid (o_mac_valid),
    .o_mac_first (o_mac_first),
    .o_mac_last  (o_mac_last),
    .o_mac_zero  (o_mac_zero),
    .o_mac_row   (o_mac_row),
    .o_count     (o_count),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Cycle index plus a one-cycle column-index memory: column of nnz k is k ^ 0x5A.
  always @(posedge i_clk) begin
    cyc       <= cyc + 1;
    i_col_idx <= o_rd_en ? (o_rd_addr ^ 8'h5A) : '0;
  end

  typedef struct {
    string            name;
    logic [PTR_W-1:0] ptr;
    int               stall_after;    // nnz ordinal after whose issue the stall starts (-1 none)
    int               stall_len;
    int               restart_after;  // nnz ordinal after which a stray start is pulsed (-1 none)
    int               exp_err;
    int               exp_tokens;
    int               exp_rd;
    int               exp_count;
    int               exp_first_k;
    logic [15:0]      exp_zero;       // rows that receive a zero tag
    logic [15:0]      exp_first;      // indexed by element ordinal
    logic [15:0]      exp_last;
    logic [63:0]      exp_rows;       // 4-bit row per element ordinal
    int               exp_tail;       // done cycle minus last o_rd_en cycle (0 = not checked)
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [PTR_W-1:0] ptr,
                              input int stall_after, input int stall_len, input int restart_after,
                              input int exp_err, input int exp_tokens, input int exp_rd,
                              input int exp_count, input int exp_first_k,
                              input logic [15:0] exp_zero, input logic [15:0] exp_first,
                              input logic [15:0] exp_last, input logic [63:0] exp_rows,
                              input int exp_tail);
    vec_t v;
    v.name = name; v.ptr = ptr; v.stall_after = stall_after; v.stall_len = stall_len;
    v.restart_after = restart_after; v.exp_err = exp_err; v.exp_tokens = exp_tokens;
    v.exp_rd = exp_rd; v.exp_count = exp_count; v.exp_first_k = exp_first_k;
    v.exp_zero = exp_zero; v.exp_first = exp_first; v.exp_last = exp_last;
    v.exp_rows = exp_rows; v.exp_tail = exp_tail;
    return v;
  endfunction

  function automatic logic [63:0] outs_packed();
    return {27'd0, o_rd_en, o_rd_addr, o_x_rd_en, o_x_addr, o_mac_valid, o_mac_first,
            o_mac_last, o_mac_zero, o_mac_row, o_count, o_busy, o_done, o_err};
  endfunction

  task automatic run_vec(input vec_t v);
    int          s;
    int          n_rd = 0, n_mac = 0, n_zero = 0, n_err = 0;
    int          err_cyc = -1, done_cyc = -1, first_tag = -1, last_tag = -1;
    int          stall_cnt = 0;
    int          rd_cyc[64];
    bit          restart_pend = 0, prev_rd = 0;
    logic [15:0] zero_seen = '0;
    logic [IDX_W-1:0] prev_addr = '0;

    @(posedge i_clk); #1;
    i_row_ptr = v.ptr;
    i_start   = 1'b1;
    s         = cyc;
    for (int t = 0; t < 300 && done_cyc < 0; t++) begin
      @(posedge i_clk); #1;
      i_start = restart_pend;
      if (restart_pend) i_row_ptr = '0;
      restart_pend = 0;
      i_stall = (stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
      @(negedge i_clk);
      if (cyc == s + 1) begin
        check({v.name, ":busy_rise"}, o_busy, 1);
        check({v.name, ":count_clear"}, o_count, 0);
      end
      check({v.name, ":x_rd_en"}, o_x_rd_en, prev_rd);
      if (o_x_rd_en) check({v.name, ":x_addr"}, o_x_addr, prev_addr ^ 8'h5A);
      prev_rd   = o_rd_en;
      prev_addr = o_rd_addr;
      if (o_rd_en) begin
        check({v.name, ":rd_addr"}, o_rd_addr, v.exp_first_k + n_rd);
        if (n_rd < 64) rd_cyc[n_rd] = cyc;
        if (n_rd == v.stall_after) stall_cnt = v.stall_len;
        if (n_rd == v.restart_after) restart_pend = 1;
        n_rd++;
      end
      if (o_mac_valid || o_mac_zero) begin
        if (first_tag < 0) first_tag = cyc;
        last_tag = cyc;
      end
      if (o_mac_valid && n_mac < 16) begin
        check({v.name, ":mac_latency"}, cyc - rd_cyc[n_mac], 2);
        check({v.name, ":mac_first"}, o_mac_first, v.exp_first[n_mac]);
        check({v.name, ":mac_last"}, o_mac_last, v.exp_last[n_mac]);
        check({v.name, ":mac_row"}, o_mac_row, v.exp_rows[n_mac*4 +: 4]);
        check({v.name, ":mac_zero_excl"}, o_mac_zero, 0);
      end
      if (o_mac_valid) n_mac++;
      if (o_mac_zero) begin
        check({v.name, ":zero_flags"}, {o_mac_first, o_mac_last}, 0);
        zero_seen[o_mac_row] = 1'b1;
        n_zero++;
      end
      if (o_err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (o_done) begin
        done_cyc = cyc;
        check({v.name, ":busy_fall"}, o_busy, 0);
      end
    end
    i_stall = 1'b0;

    check({v.name, ":done_seen"}, done_cyc >= 0, 1);
    check({v.name, ":err_pulses"}, n_err, v.exp_err);
    check({v.name, ":rd_count"}, n_rd, v.exp_rd);
    check({v.name, ":tokens"}, n_mac + n_zero, v.exp_tokens);
    check({v.name, ":zero_rows"}, zero_seen, v.exp_zero);
    check({v.name, ":o_count"}, o_count, v.exp_count);
    if (v.exp_err != 0) begin
      check({v.name, ":err_cycle"}, err_cyc - s, 2);
      check({v.name, ":done_after_err"}, done_cyc - err_cyc, 1);
    end else begin
      check({v.name, ":done_after_tag"}, done_cyc - last_tag, 1);
      check({v.name, ":token_span"}, last_tag - first_tag, v.exp_tokens - 1 + v.stall_len);
    end
    if (v.exp_tail > 0 && n_rd > 0 && n_rd <= 64)
      check({v.name, ":done_after_issue"}, done_cyc - rd_cyc[n_rd-1], v.exp_tail);

    @(negedge i_clk);
    check({v.name, ":done_one_cycle"}, o_done, 0);
    check({v.name, ":count_hold"}, o_count, v.exp_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PTR_W-1:0] p_csr, p_ramp, p_bad, p_lead;
    bit               found;
    int               seen;

    p_csr  = {8'h0a, 8'h09, 8'h09, 8'h09, 8'h07, 8'h07, 8'h07, 8'h07, 8'h04,
              8'h04, 8'h04, 8'h03, 8'h02, 8'h02, 8'h01, 8'h00, 8'h00};
    p_bad  = {{11{8'h03}}, 8'h01, 8'h02, 8'h02, 8'h01, 8'h01, 8'h00};
    p_lead = {{9{8'h22}}, {8{8'h20}}};
    for (int j = 0; j <= N_ROWS; j++) p_ramp[j*IDX_W +: IDX_W] = IDX_W'(j);

    //            name       ptr      stall   len restart err tok rd cnt k0
    vecs[0] = mk("csr",     p_csr,   -1,     0,  -1,     0,  19, 10, 10, 0,
                 16'h6EC9, 16'h029F, 16'h034F, 64'h0000_00FC_C888_5421, 3);
    vecs[1] = mk("allzero", '0,      -1,     0,  -1,     0,  16, 0,  0,  0,
                 16'hFFFF, 16'h0000, 16'h0000, 64'h0, 0);
    vecs[2] = mk("stall",   p_csr,    4,     3,  -1,     0,  19, 10, 10, 0,
                 16'h6EC9, 16'h029F, 16'h034F, 64'h0000_00FC_C888_5421, 3);
    vecs[3] = mk("badptr",  p_bad,   -1,     0,  -1,     1,  0,  0,  0,  0,
                 16'h0000, 16'h0000, 16'h0000, 64'h0, 0);
    vecs[4] = mk("restart", p_csr,   -1,     0,   2,     0,  19, 10, 10, 0,
                 16'h6EC9, 16'h029F, 16'h034F, 64'h0000_00FC_C888_5421, 3);
    vecs[5] = mk("ramp",    p_ramp,  -1,     0,  -1,     0,  16, 16, 16, 0,
                 16'h0000, 16'hFFFF, 16'hFFFF, 64'hFEDC_BA98_7654_3210, 3);

    i_rstn    = 1'b0;
    i_start   = 1'b0;
    i_stall   = 1'b0;
    i_row_ptr = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs", outs_packed(), 64'd0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("idle_outputs", outs_packed(), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    run_vec(mk("leading", p_lead, -1, 0, -1, 0, 17, 2, 2, 8'h20,
               16'hFF7F, 16'h0001, 16'h0002, 64'h77, 11));

    // Abort mid-run with reset, then confirm a fresh multiply still completes.
    @(posedge i_clk); #1;
    i_row_ptr = p_csr;
    i_start   = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    found   = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge i_clk);
      if (o_rd_en && o_rd_addr == 8'd3) found = 1;
    end
    check("reset_point_reached", found, 1);
    #2;
    i_rstn = 1'b0;
    #1;
    check("async_reset_outputs", outs_packed(), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge i_clk);
      if (o_done || o_busy || o_mac_valid || o_mac_zero) seen++;
    end
    check("quiet_after_reset", seen, 0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
